// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding, frame width, divisor.
// Latency: n/a (package, no logic).
// Backpressure: n/a.
package uart_pkg;

    // Number of data bits per frame, sent LSB first.
    localparam int DATA_BITS = 8;

    // Transmitter FSM states. PARITY is only visited when parity is built in.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // Clock cycles per line bit; integer division, evaluated at elaboration.
    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// Synchronous FIFO holding bytes waiting for the UART transmitter.
// Latency: a pushed entry is visible on dout / count from the next cycle.
// Backpressure: none internally; the caller only pushes when not full (or popping) and pops when non-empty.
//
// Ports:
//   clk, rst    - clock, synchronous active-high reset (flushes pointers and count)
//   push, din   - write strobe and data
//   pop, dout   - read strobe; dout is the head entry (combinational read)
//   count       - occupancy, 0..DEPTH
module tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign dout = mem[rd_ptr];

    // Storage carries no reset; the caller never pushes during reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter (8 data bits, LSB first, 1 stop bit) fed by a byte FIFO.
// Latency: wr into an empty FIFO with the line idle -> pop next cycle -> start bit on txd the cycle after.
// Backpressure: full flags a full FIFO; a wr while full is dropped unless a pop happens in the same cycle.
//
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset (aborts any frame, flushes the FIFO)
//   denv  - byte to enqueue, sampled when wr=1
//   wr    - write strobe, one byte per cycle
//   txd   - serial line, idle high, registered
//   busy  - registered: FIFO non-empty or a frame in progress
//   full  - registered: FIFO holds fifo_depth bytes
//
// Optional build macro UART_TX_PARITY_EN: inserts an even-parity bit between data and stop.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int clk_freq   = 50000000,
    parameter int baud       = 115200,
    parameter int fifo_depth = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] denv,
    input  logic       wr,
    output logic       txd,
    output logic       busy,
    output logic       full
);

    localparam int DIV = calc_div(clk_freq, baud);
    localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW  = $clog2(fifo_depth) + 1;
    localparam int BCW = $clog2(DATA_BITS);

    uart_state_t            state;
    logic [BW-1:0]          baud_cnt;
    logic [BCW-1:0]         bit_cnt;
    logic [DATA_BITS-1:0]   shreg;
`ifdef UART_TX_PARITY_EN
    logic                   par;
`endif

    logic [CW-1:0]          count;
    logic [CW-1:0]          cnt_nxt;
    logic [DATA_BITS-1:0]   fifo_dout;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   baud_end;
    logic                   push;
    logic                   pop;
    logic                   frame_nxt;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(fifo_depth));
    assign baud_end   = (baud_cnt == BW'(DIV - 1));

    // Pop either from IDLE or at the last cycle of the stop bit, so frames run
    // back-to-back. Emptiness comes from the registered count, so a byte written
    // this cycle cannot be popped until the next one.
    assign pop = !rst && !fifo_empty &&
                 ((state == ST_IDLE) || ((state == ST_STOP) && baud_end));

    // A full FIFO still accepts a write when a pop frees a slot in the same cycle.
    assign push = !rst && wr && (!fifo_full || pop);

    always_comb begin
        cnt_nxt = count;
        if (push && !pop) begin
            cnt_nxt = count + CW'(1);
        end else if (!push && pop) begin
            cnt_nxt = count - CW'(1);
        end
    end

    // Whether a frame is in progress after this edge.
    always_comb begin
        frame_nxt = 1'b1;
        if (state == ST_IDLE) begin
            frame_nxt = pop;
        end else if ((state == ST_STOP) && baud_end && !pop) begin
            frame_nxt = 1'b0;
        end
    end

    tx_fifo #(
        .DEPTH (fifo_depth),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (denv),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            txd      <= 1'b1;
            busy     <= 1'b0;
            full     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            full <= (cnt_nxt == CW'(fifo_depth));
            busy <= (cnt_nxt != '0) || frame_nxt;

            case (state)
                ST_IDLE: begin
                    baud_cnt <= '0;
                    if (pop) begin
                        shreg <= fifo_dout;
`ifdef UART_TX_PARITY_EN
                        par   <= ^fifo_dout;
`endif
                        state <= ST_START;
                        txd   <= 1'b0;
                    end
                end

                ST_START: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= ST_DATA;
                        txd      <= shreg[0];
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end

                ST_DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == BCW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                            state <= ST_PARITY;
                            txd   <= par;
`else
                            state <= ST_STOP;
                            txd   <= 1'b1;
`endif
                        end else begin
                            // Shift so the next data bit sits at shreg[0].
                            bit_cnt <= bit_cnt + BCW'(1);
                            shreg   <= shreg >> 1;
                            txd     <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end

`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        state    <= ST_STOP;
                        txd      <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
`endif

                ST_STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shreg <= fifo_dout;
`ifdef UART_TX_PARITY_EN
                            par   <= ^fifo_dout;
`endif
                            state <= ST_START;
                            txd   <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                            txd   <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end

                default: begin
                    state    <= ST_IDLE;
                    baud_cnt <= '0;
                    txd      <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: line-level model plus directed scenarios.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_tx_fifo;

    localparam int CLK_FREQ = 1000;
    localparam int BAUD     = 100;
    localparam int DIV      = 10;
    localparam int DEPTH    = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * DIV;

    logic       clk;
    logic       rst;
    logic [7:0] denv;
    logic       wr;
    logic       txd;
    logic       busy;
    logic       full;

    int n_cmp;
    int n_err;
    int edge_cnt;
    bit chk_en;

    uart_tx_fifo #(
        .clk_freq   (CLK_FREQ),
        .baud       (BAUD),
        .fifo_depth (DEPTH)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .denv (denv),
        .wr   (wr),
        .txd  (txd),
        .busy (busy),
        .full (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_cnt, act, exp);
        end
    endtask

    // ---------------------------------------------------------------
    // Line model: a queue of waiting bytes and a queue of future line
    // bits, one entry per clock cycle. A byte leaves the queue the
    // moment the line has nothing left to send.
    // ---------------------------------------------------------------
    logic [7:0] mq[$];
    bit         lq[$];
    bit         exp_txd;
    bit         exp_busy;
    bit         exp_full;

    task automatic append_frame(input logic [7:0] b);
        bit bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
        bits.push_back(^b);
`endif
        bits.push_back(1'b1);
        foreach (bits[i]) for (int k = 0; k < DIV; k++) lq.push_back(bits[i]);
    endtask

    always begin
        @(posedge clk);
        if (rst) begin
            mq.delete();
            lq.delete();
        end else begin
            if (lq.size() > 0) void'(lq.pop_front());
            if (lq.size() == 0 && mq.size() > 0) append_frame(mq.pop_front());
            if (wr && mq.size() < DEPTH) mq.push_back(denv);
        end
        exp_txd  = (lq.size() > 0) ? lq[0] : 1'b1;
        exp_busy = (mq.size() != 0) || (lq.size() != 0);
        exp_full = (mq.size() == DEPTH);
        #1;
        if (chk_en) begin
            check("model_txd",  {31'd0, txd},  {31'd0, exp_txd});
            check("model_busy", {31'd0, busy}, {31'd0, exp_busy});
            check("model_full", {31'd0, full}, {31'd0, exp_full});
        end
    end

    // ---------------------------------------------------------------
    // Independent line receiver: samples mid-bit, collects bytes.
    // ---------------------------------------------------------------
    logic [7:0] rx_q[$];
    logic [7:0] rx_sh;
    int         rx_t;
    bit         rx_on;

    always begin
        @(posedge clk);
        #2;
        if (rst) begin
            rx_on = 1'b0;
        end else if (!rx_on) begin
            if (txd === 1'b0) begin
                rx_on = 1'b1;
                rx_t  = 0;
            end
        end else begin
            rx_t++;
            if (rx_t % DIV == DIV / 2) begin
                if (rx_t / DIV >= 1 && rx_t / DIV <= 8) rx_sh[rx_t / DIV - 1] = txd;
                if (rx_t / DIV == 8) rx_q.push_back(rx_sh);
                if (rx_t / DIV == FRAME_BITS - 1) rx_on = 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------
    // Stimulus helpers
    // ---------------------------------------------------------------
    logic [7:0] stim[$];
    logic [7:0] exp_rx[$];

    // Drives stim[] on consecutive cycles; e1 is the edge capturing the first byte.
    task automatic send_stim(output int e1);
        e1 = 0;
        foreach (stim[i]) begin
            @(negedge clk);
            if (i == 0) e1 = edge_cnt + 1;
            wr   = 1'b1;
            denv = stim[i];
        end
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (busy === 1'b0) break;
        end
        check(name, {31'd0, busy}, 32'd0);
    endtask

    task automatic check_rx(input string name);
        check({name, "_cnt"}, rx_q.size(), exp_rx.size());
        foreach (exp_rx[i]) begin
            if (i < rx_q.size()) check({name, "_byte"}, {24'd0, rx_q[i]}, {24'd0, exp_rx[i]});
        end
    endtask

    initial begin
        int e1;
        n_cmp    = 0;
        n_err    = 0;
        edge_cnt = 0;
        chk_en   = 1'b0;
        rst      = 1'b1;
        wr       = 1'b0;
        denv     = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        rst = 1'b0;
        check("rst_txd",  {31'd0, txd},  32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_full", {31'd0, full}, 32'd0);

        // Single byte 0x55: start bit from N+2, bits alternate 1/0, busy drops after stop
        rx_q.delete();
        stim = '{8'h55};
        send_stim(e1);
        @(posedge clk); #1;
        check("single_start", {31'd0, txd}, 32'd0);
        repeat (10) @(posedge clk); #1;
        check("single_bit0", {31'd0, txd}, 32'd1);
        repeat (10) @(posedge clk); #1;
        check("single_bit1", {31'd0, txd}, 32'd0);
        repeat (FRAME_CYC - 21) @(posedge clk); #1;
        check("single_stop_txd",  {31'd0, txd},  32'd1);
        check("single_stop_busy", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        check("single_end_busy", {31'd0, busy}, 32'd0);
        exp_rx = '{8'h55};
        check_rx("single_rx");

        // Back-to-back 0x01..0x05: FIFO fills after one pop, all frames contiguous
        repeat (5) @(negedge clk);
        rx_q.delete();
        stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        send_stim(e1);
        check("b2b_full", {31'd0, full}, 32'd1);
        wait_idle("b2b_idle", 8 * FRAME_CYC);
        exp_rx = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        check_rx("b2b_rx");

        // Overflow: FIFO full mid-frame, 0xEE must be dropped
        repeat (5) @(negedge clk);
        rx_q.delete();
        stim = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h66, 8'hEE};
        send_stim(e1);
        check("ovf_full", {31'd0, full}, 32'd1);
        wait_idle("ovf_idle", 8 * FRAME_CYC);
        exp_rx = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h66};
        check_rx("ovf_rx");

        // Write while full, coincident with the stop-to-start pop: accepted
        repeat (5) @(negedge clk);
        rx_q.delete();
        stim = '{8'h81, 8'h82, 8'h83, 8'h84, 8'h85};
        send_stim(e1);
        while (edge_cnt + 1 < e1 + 1 + FRAME_CYC) @(negedge clk);
        wr   = 1'b1;
        denv = 8'h86;
        @(negedge clk);
        wr = 1'b0;
        check("sim_full", {31'd0, full}, 32'd1);
        wait_idle("sim_idle", 9 * FRAME_CYC);
        exp_rx = '{8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86};
        check_rx("sim_rx");

        // Reset during data bit 3 of 0xA5 with two bytes queued; wr in reset cycle dropped
        repeat (5) @(negedge clk);
        rx_q.delete();
        stim = '{8'hA5, 8'h01, 8'h02};
        send_stim(e1);
        while (edge_cnt + 1 < e1 + 1 + 4 * DIV + DIV / 2) @(negedge clk);
        check("mid_txd_low", {31'd0, txd}, 32'd0);
        rst  = 1'b1;
        wr   = 1'b1;
        denv = 8'h77;
        @(posedge clk); #1;
        check("mid_rst_txd",  {31'd0, txd},  32'd1);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_full", {31'd0, full}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wr  = 1'b0;
        repeat (3 * FRAME_CYC) @(posedge clk); #1;
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        check("post_rst_txd",  {31'd0, txd},  32'd1);
        exp_rx.delete();
        check_rx("post_rst_rx");

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter clk_freq, default 50000000, system clock frequency in Hz.
REQ-002 Parameter baud, default 115200, line bit rate in bit/s.
REQ-003 Parameter fifo_depth, default 4, transmit FIFO entries, power of two, at least 2.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 denv  in  8  byte to send; sampled when wr=1.
REQ-007 wr  in  1  write strobe; one byte enqueued per cycle high.
REQ-008 txd  out  1  serial line; idle high.
REQ-009 busy  out  1  high while FIFO non-empty or a frame is in progress.
REQ-010 full  out  1  high while FIFO holds fifo_depth bytes.

Function
REQ-011 Divisor DIV SHALL be clk_freq/baud, integer division, computed at elaboration; every line bit is held exactly DIV clk cycles.
REQ-012 Frame SHALL be: start (0), 8 data bits LSB first, optional parity (see REQ-023), stop (1).
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; bit counter 0..7 in DATA; baud counter 0..DIV-1 restarting on every state entry.
REQ-014 IDLE with FIFO non-empty SHALL pop one byte into the shift register and enter START in the same cycle.
REQ-015 Latency: wr at cycle N with FIFO empty and FSM in IDLE -> pop at N+1, txd=0 from N+2.
REQ-016 STOP end with FIFO non-empty SHALL pop and enter START directly, so the next start bit follows the stop bit with no idle gap; with FIFO empty, return to IDLE.
REQ-017 wr while full and no pop in that cycle SHALL be ignored; FIFO contents, pointers and the current frame SHALL be unchanged.
REQ-018 wr while full in the same cycle as a pop SHALL be accepted.
REQ-019 wr into an empty FIFO SHALL NOT be popped in the same cycle; it is popped from the next cycle.
REQ-020 FIFO pointers SHALL wrap modulo fifo_depth; full/empty SHALL be derived from an occupancy count of width log2(fifo_depth)+1.
REQ-021 busy and full SHALL be registered and reflect state at the same edge as the FIFO/FSM update.

Reset
REQ-022 On rst=1 at a clock edge: FSM goes to IDLE, FIFO is flushed (count 0), counters are cleared, txd=1, busy=0, full=0. This applies even mid-frame, with txd high from the next cycle. A wr in a reset cycle SHALL be discarded.

Configuration
REQ-023 Macro UART_TX_PARITY_EN: when defined, the PARITY state is inserted after DATA, emitting even parity (XOR of the 8 data bits) for DIV cycles, giving an 11-bit frame. When undefined, DATA goes directly to STOP (10-bit frame) and no parity logic is generated.

Structure
REQ-024 Shared package uart_pkg SHALL hold the FSM state encoding, a DATA_BITS=8 constant and the divisor computation function.
REQ-025 The FIFO SHALL be a sub-module tx_fifo (synchronous, parameterised depth, push/pop/count); the FSM and baud counter stay in uart_tx_fifo.

Verification (clk_freq=1000, baud=100, DIV=10, fifo_depth=4)
REQ-026 Single byte: wr with denv=0x55 -> txd=0 at N+2 for 10 cycles, then 1,0,1,0,1,0,1,0 (10 cycles each), stop 1; busy falls after the stop bit ends.
REQ-027 Back-to-back: 5 writes 0x01..0x05 on consecutive cycles -> full high after the 4th write less one pop, no byte lost; 5 contiguous frames, no idle gap between them.
REQ-028 Overflow: fill FIFO mid-frame (full=1), wr 0xEE -> 0xEE never appears on txd; count unchanged.
REQ-029 Reset mid-frame: rst at bit 3 of 0xA5 with 2 bytes queued -> txd=1 the next cycle, busy=0, full=0; no further frames.
REQ-030 Parity build: with UART_TX_PARITY_EN defined, 0x07 -> parity bit 1, frame 110 cycles; with it undefined, frame 100 cycles.
REQ-031 Simultaneous: wr while full, coincident with a STOP-to-START pop -> byte accepted, full stays 1.
